fft_frame_tx: RTL and testbench
===============================

// Module: fft_frame_tx
// PURPOSE
//  Ping-pong frame buffer and streamer: transmit end of the FFT bin stream.
//  Accepts bins randomly addressed by the FFT core and emits whole frames of
//  BATCH_SIZE entries in natural bin order on a sop/eop/valid/re/im stream.
//  Sits between the FFT core and peak_detect; one frame = one detection batch.
// PARAMETERS
//  BATCH_SIZE  1024  entries per frame; power of two, >= 4
//  DATA_WIDTH  16    bits per re/im entry, two's complement
//  BITREV      0     1: entry k is read from bank address bitreverse(k)
//  MIN_GAP     8     idle cycles forced between eop of one frame and next sop
// PORTS
//  clk          in   1                    clock
//  reset        in   1                    synchronous, active-high
//  wr_en        in   1                    write wr_re/wr_im to write bank at wr_addr
//  wr_addr      in   $clog2(BATCH_SIZE)   bank address of write
//  wr_re        in   DATA_WIDTH           real part to store
//  wr_im        in   DATA_WIDTH           imaginary part to store
//  wr_commit    in   1                    write bank complete; hand it to reader
//  wr_ready     out  1                    a write bank is free (not queued/streaming)
//  overflow     out  1                    sticky: commit arrived with no free bank
//  source_sop   out  1                    first entry of frame
//  source_eop   out  1                    last entry of frame
//  source_valid out  1                    entry valid
//  source_re    out  DATA_WIDTH           real part of entry
//  source_im    out  DATA_WIDTH           imaginary part of entry
// BEHAVIOUR
//  - Reset (sync): both banks free, write ptr = bank 0, read FSM IDLE, gap
//    counter 0, all outputs 0 except wr_ready = 1. Reset mid-frame aborts the
//    frame: no eop is emitted, outputs are 0 from the next cycle on.
//  - Bank state: FREE -> FULL on commit -> STREAMING -> FREE after eop.
//    Frames are streamed in commit order; writer toggles bank on each accepted commit.
//  - wr_ready = write bank is FREE. wr_en with wr_ready=0 is ignored.
//  - wr_en and wr_commit in the same cycle: the write lands in the committed frame.
//  - wr_commit with wr_ready=0: ignored, overflow <= 1 until reset; bank
//    contents and pointers unchanged.
//  - Read FSM: IDLE -> READ when the oldest bank is FULL; READ issues addresses
//    k = 0..BATCH_SIZE-1, one per cycle, no stalls; -> GAP after k = BATCH_SIZE-1;
//    GAP holds MIN_GAP cycles (MIN_GAP=0: direct) -> READ if next bank FULL, else IDLE.
//  - Memory read is 1 cycle; outputs registered. Commit sampled at edge T with
//    FSM IDLE -> entry 0 (valid, sop) visible after edge T+2; entry k after T+2+k.
//  - sop with k=0, eop with k=BATCH_SIZE-1, both with valid; re/im = 0 when valid=0.
//  - Back-to-back: eop at cycle E -> next sop no earlier than E+MIN_GAP+1.
//  - Bank freed (wr_ready may rise) on the cycle after eop is presented.
//  - Same-cycle commit and end of stream: freed bank seen by writer next cycle only.
//  - BITREV=1: address = k with bits reversed over $clog2(BATCH_SIZE) bits.
//  - No data arithmetic; values passed bit-exact.
// TESTING
//  1 write bank0 addr a <- re=a, im=-a, commit at T -> sop/valid after T+2,
//    re=0..1023 in order, eop with re=1023, wr_ready stays 1.
//  2 commit two frames back-to-back, MIN_GAP=8 -> second sop exactly 9 cycles
//    after first eop; wr_ready=0 while both banks in use.
//  3 third commit while both banks FULL/STREAMING -> overflow=1 sticky,
//    streamed frames unchanged, no extra frame emitted.
//  4 BITREV=1, BATCH_SIZE=8, bank addr a <- re=a -> stream re = 0,4,2,6,1,5,3,7.
//  5 reset asserted at entry 500 of frame -> valid=0 next cycle, no eop,
//    wr_ready=1, overflow=0; new commit streams normally.
//  6 wr_en+wr_commit same cycle at addr 1023 -> that value appears at eop.

Source files
------------

// File: rtl/fft_frame_tx.sv
// Ping-pong frame buffer: the FFT core fills one bank at random addresses while the
// other streams out as a sop/eop framed burst in natural (or bit-reversed) bin order.
`timescale 1ns/1ps
module fft_frame_tx #(
    parameter int BATCH_SIZE = 1024,
    parameter int DATA_WIDTH = 16,
    parameter int BITREV     = 0,
    parameter int MIN_GAP    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [$clog2(BATCH_SIZE)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_re,
    input  logic [DATA_WIDTH-1:0]         wr_im,
    input  logic                          wr_commit,
    output logic                          wr_ready,
    output logic                          overflow,
    output logic                          source_sop,
    output logic                          source_eop,
    output logic                          source_valid,
    output logic [DATA_WIDTH-1:0]         source_re,
    output logic [DATA_WIDTH-1:0]         source_im
);
    localparam int AW = $clog2(BATCH_SIZE);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [AW-1:0] K_LAST   = AW'(BATCH_SIZE - 1);

    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_READ = 2'd1, RD_GAP = 2'd2} rd_state_t;
    typedef enum logic [1:0] {BANK_FREE = 2'd0, BANK_FULL = 2'd1, BANK_STREAM = 2'd2} bank_state_t;

    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] mem_re [2*BATCH_SIZE];
    logic [DATA_WIDTH-1:0] mem_im [2*BATCH_SIZE];

    rd_state_t             rd_state_r, rd_state_s;
    bank_state_t           bank_r [2];
    bank_state_t           bank_s [2];
    logic [AW-1:0]         k_r;
    logic [GW-1:0]         gap_cnt_r;
    logic                  wr_bank_r, wr_bank_s;
    logic                  rd_bank_r, cur_bank_r, out_bank_r;
    logic                  wr_ready_r, overflow_r;
    logic                  sop_r, eop_r, valid_r;
    logic [DATA_WIDTH-1:0] re_r, im_r;
    logic                  next_full_s, reading_s, last_s, start_s, commit_ok_s;
    logic [AW:0]           rd_addr_s;

    assign next_full_s = (bank_r[rd_bank_r] == BANK_FULL);
    assign commit_ok_s = wr_commit && wr_ready_r;

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_r <= RD_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Read FSM next-state logic
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            RD_IDLE: rd_state_s = next_full_s ? RD_READ : RD_IDLE;
            RD_READ: begin
                if (k_r != K_LAST) begin
                    rd_state_s = RD_READ;
                end else if (MIN_GAP > 0) begin
                    rd_state_s = RD_GAP;
                end else begin
                    rd_state_s = next_full_s ? RD_READ : RD_IDLE;
                end
            end
            RD_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    rd_state_s = next_full_s ? RD_READ : RD_IDLE;
                end else begin
                    rd_state_s = RD_GAP;
                end
            end
            default: rd_state_s = RD_IDLE;
        endcase
    end

    // Read FSM outputs: start_s marks the edge a new frame begins streaming
    always_comb begin
        reading_s = (rd_state_r == RD_READ);
        last_s    = reading_s && (k_r == K_LAST);
        start_s   = 1'b0;
        case (rd_state_r)
            RD_IDLE: start_s = next_full_s;
            RD_READ: start_s = last_s && (MIN_GAP == 0) && next_full_s;
            RD_GAP:  start_s = (gap_cnt_r == GAP_LAST) && next_full_s;
            default: start_s = 1'b0;
        endcase
    end

    // Next bank states; a commit, a stream start and an eop free never hit the same bank
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            if (commit_ok_s && (wr_bank_r == 1'(b))) begin
                bank_s[b] = BANK_FULL;
            end else if (start_s && (rd_bank_r == 1'(b))) begin
                bank_s[b] = BANK_STREAM;
            end else if (eop_r && (out_bank_r == 1'(b))) begin
                bank_s[b] = BANK_FREE;
            end else begin
                bank_s[b] = bank_r[b];
            end
        end
        wr_bank_s = commit_ok_s ? ~wr_bank_r : wr_bank_r;
        rd_addr_s = {cur_bank_r, (BITREV != 0) ? bit_reverse(k_r) : k_r};
    end

    // Bank bookkeeping, writer pointer and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_r[0]  <= BANK_FREE;
            bank_r[1]  <= BANK_FREE;
            wr_bank_r  <= 1'b0;
            wr_ready_r <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            bank_r[0]  <= bank_s[0];
            bank_r[1]  <= bank_s[1];
            wr_bank_r  <= wr_bank_s;
            wr_ready_r <= (bank_s[wr_bank_s] == BANK_FREE);
            if (wr_commit && !wr_ready_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Bank write port; a write in the commit cycle still lands in the committed bank
    always_ff @(posedge clk) begin
        if (wr_en && wr_ready_r) begin
            mem_re[{wr_bank_r, wr_addr}] <= wr_re;
            mem_im[{wr_bank_r, wr_addr}] <= wr_im;
        end
    end

    // Read counters and the registered stream outputs (memory read folded in)
    always_ff @(posedge clk) begin
        if (reset) begin
            k_r        <= '0;
            gap_cnt_r  <= '0;
            rd_bank_r  <= 1'b0;
            cur_bank_r <= 1'b0;
            out_bank_r <= 1'b0;
            valid_r    <= 1'b0;
            sop_r      <= 1'b0;
            eop_r      <= 1'b0;
            re_r       <= '0;
            im_r       <= '0;
        end else begin
            if (start_s) begin
                k_r        <= '0;
                cur_bank_r <= rd_bank_r;
                rd_bank_r  <= ~rd_bank_r;
            end else if (reading_s) begin
                k_r <= k_r + 1'b1;
            end
            gap_cnt_r  <= (rd_state_r == RD_GAP) ? gap_cnt_r + 1'b1 : '0;
            out_bank_r <= cur_bank_r;
            valid_r    <= reading_s;
            sop_r      <= reading_s && (k_r == '0);
            eop_r      <= last_s;
            re_r       <= reading_s ? mem_re[rd_addr_s] : '0;
            im_r       <= reading_s ? mem_im[rd_addr_s] : '0;
        end
    end

    assign wr_ready     = wr_ready_r;
    assign overflow     = overflow_r;
    assign source_sop   = sop_r;
    assign source_eop   = eop_r;
    assign source_valid = valid_r;
    assign source_re    = re_r;
    assign source_im    = im_r;
endmodule

// File: tb/tb_fft_frame_tx.sv
// Directed bench for fft_frame_tx: a 1024-entry natural-order instance and an
// 8-entry bit-reversed instance with no inter-frame gap.
`timescale 1ns/1ps
module tb_fft_frame_tx;
    localparam int N  = 1024;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          reset;
    logic          wr_en, wr_commit, wr_ready, overflow;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_re, wr_im, source_re, source_im;
    logic          source_sop, source_eop, source_valid;

    logic          br_wr_en, br_wr_commit, br_wr_ready, br_overflow;
    logic [2:0]    br_wr_addr;
    logic [DW-1:0] br_wr_re, br_wr_im, br_re, br_im;
    logic          br_sop, br_eop, br_valid;

    fft_frame_tx #(.BATCH_SIZE(N), .DATA_WIDTH(DW), .BITREV(0), .MIN_GAP(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re),
        .wr_im(wr_im), .wr_commit(wr_commit), .wr_ready(wr_ready), .overflow(overflow),
        .source_sop(source_sop), .source_eop(source_eop), .source_valid(source_valid),
        .source_re(source_re), .source_im(source_im));

    fft_frame_tx #(.BATCH_SIZE(NB), .DATA_WIDTH(DW), .BITREV(1), .MIN_GAP(0)) dut_br (
        .clk(clk), .reset(reset), .wr_en(br_wr_en), .wr_addr(br_wr_addr), .wr_re(br_wr_re),
        .wr_im(br_wr_im), .wr_commit(br_wr_commit), .wr_ready(br_wr_ready),
        .overflow(br_overflow), .source_sop(br_sop), .source_eop(br_eop),
        .source_valid(br_valid), .source_re(br_re), .source_im(br_im));

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fill_bank(input int base, input bit commit_last);
        for (int a = 0; a < N; a++) begin
            wr_en     = 1'b1;
            wr_addr   = AW'(a);
            wr_re     = DW'(base + a);
            wr_im     = DW'(-(base + a));
            wr_commit = commit_last && (a == N - 1);
            @(negedge clk);
        end
        wr_en     = 1'b0;
        wr_commit = 1'b0;
    endtask

    task automatic do_commit();
        wr_commit = 1'b1;
        @(negedge clk);
        wr_commit = 1'b0;
    endtask

    // Waits (bounded) for sop, then checks every entry; returns at the eop negedge.
    task automatic recv_frame(input int base, input string tag, output int sop_cyc,
                              output int eop_cyc, output logic [DW-1:0] last_re);
        int waited = 0;
        int bad = 0;
        while (!source_valid && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, "_start"}, 32'(waited < 3000), 32'd1);
        sop_cyc = cyc;
        eop_cyc = 0;
        last_re = '0;
        for (int k = 0; k < N; k++) begin
            if (source_valid !== 1'b1 || source_sop !== (k == 0) || source_eop !== (k == N - 1) ||
                source_re !== DW'(base + k) || source_im !== DW'(-(base + k))) bad++;
            if (k == N - 1) begin
                eop_cyc = cyc;
                last_re = source_re;
            end else begin
                @(negedge clk);
            end
        end
        check_val({tag, "_entries_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rev8 [NB] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int s1, e1, s2, e2, cnt;
        logic [DW-1:0] lr;

        reset = 1'b1; wr_en = 1'b0; wr_commit = 1'b0; wr_addr = '0; wr_re = '0; wr_im = '0;
        br_wr_en = 1'b0; br_wr_commit = 1'b0; br_wr_addr = '0; br_wr_re = '0; br_wr_im = '0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", 32'(source_valid), 32'd0);
        check_val("rst_sop_eop", 32'({source_sop, source_eop}), 32'd0);
        check_val("rst_re_im", {source_re, source_im}, 32'd0);
        check_val("rst_wr_ready", 32'(wr_ready), 32'd1);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_br_ready", 32'(br_wr_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Bit-reversed, gapless: two frames back to back
        for (int a = 0; a < NB; a++) begin
            br_wr_en = 1'b1; br_wr_addr = 3'(a); br_wr_re = DW'(a); br_wr_im = DW'(-a);
            br_wr_commit = (a == NB - 1);
            @(negedge clk);
        end
        br_wr_en = 1'b0; br_wr_commit = 1'b0;
        fork
            begin
                for (int a = 0; a < NB; a++) begin
                    br_wr_en = 1'b1; br_wr_addr = 3'(a); br_wr_re = DW'(a + 8); br_wr_im = DW'(-(a + 8));
                    br_wr_commit = (a == NB - 1);
                    @(negedge clk);
                end
                br_wr_en = 1'b0; br_wr_commit = 1'b0;
                check_val("br_ready_both_busy", 32'(br_wr_ready), 32'd0);
            end
            begin
                int w = 0;
                int badf = 0;
                while (!br_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                check_val("br_latency", 32'(w), 32'd2);
                for (int i = 0; i < 2 * NB; i++) begin
                    check_val($sformatf("br_re_%0d", i), 32'(br_re), 32'(rev8[i % NB] + ((i >= NB) ? 8 : 0)));
                    if (br_valid !== 1'b1 || br_sop !== (i % NB == 0) || br_eop !== (i % NB == NB - 1)) badf++;
                    @(negedge clk);
                end
                check_val("br_flags_bad", 32'(badf), 32'd0);
                check_val("br_idle_after", 32'(br_valid), 32'd0);
            end
        join

        // 1: single frame, latency and ordering
        fill_bank(0, 1'b0);
        do_commit();
        check_val("t1_lat_c1", 32'(source_valid), 32'd0);
        @(negedge clk);
        check_val("t1_lat_c2", 32'(source_valid), 32'd0);
        @(negedge clk);
        check_val("t1_sop_at_t2", 32'({source_valid, source_sop}), 32'd3);
        check_val("t1_ready_streaming", 32'(wr_ready), 32'd1);
        recv_frame(0, "t1", s1, e1, lr);
        check_val("t1_eop_re", 32'(lr), 32'd1023);
        @(negedge clk);
        check_val("t1_idle_after", 32'(source_valid), 32'd0);
        check_val("t1_ready_after", 32'(wr_ready), 32'd1);

        // 2: back to back with gap; 3: commit while no bank is free
        fill_bank(4096, 1'b0);
        do_commit();
        fork
            begin
                fill_bank(8192, 1'b1);
                check_val("t2_ready_both_busy", 32'(wr_ready), 32'd0);
            end
            recv_frame(4096, "t2a", s1, e1, lr);
        join
        wr_commit = 1'b1;
        @(negedge clk);
        wr_commit = 1'b0;
        check_val("t3_overflow", 32'(overflow), 32'd1);
        check_val("t3_ready_after_eop", 32'(wr_ready), 32'd1);
        recv_frame(8192, "t2b", s2, e2, lr);
        check_val("t2_gap", 32'(s2 - e1), 32'd9);
        @(negedge clk);
        cnt = 0;
        repeat (40) begin
            if (source_valid) cnt++;
            @(negedge clk);
        end
        check_val("t3_no_extra_frame", 32'(cnt), 32'd0);
        check_val("t3_overflow_sticky", 32'(overflow), 32'd1);

        // 5: reset in the middle of a frame
        fill_bank(12288, 1'b1);
        cnt = 0;
        while (!source_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        repeat (500) @(negedge clk);
        check_val("t5_entry500", 32'(source_re), 32'd12788);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("t5_valid_eop", 32'({source_valid, source_eop}), 32'd0);
        check_val("t5_re", 32'(source_re), 32'd0);
        check_val("t5_ready", 32'(wr_ready), 32'd1);
        check_val("t5_overflow", 32'(overflow), 32'd0);
        cnt = 0;
        repeat (20) begin
            if (source_valid || source_eop) cnt++;
            @(negedge clk);
        end
        check_val("t5_quiet", 32'(cnt), 32'd0);

        // 6: last write and commit in the same cycle
        fill_bank(16384, 1'b1);
        recv_frame(16384, "t6", s1, e1, lr);
        check_val("t6_eop_re", 32'(lr), 32'd17407);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
